// File: rtl/pixel_streamer_pkg.sv
// Shared definitions for the pixel streamer: width helper and FSM encoding.
package pixel_streamer_pkg;

  // Bits needed to index n items (minimum 1).
  function automatic int count2width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_streamer_if.sv
// Pixel-stream link between the streamer (master) and the window line buffer (slave).
interface pixel_streamer_if #(
  parameter int FIXED_POINT_SIZE = 16
) ();
  logic [FIXED_POINT_SIZE-1:0] dataOut;
  logic                        dataValidOut;

  modport master (output dataOut, output dataValidOut);
  modport slave  (input  dataOut, input  dataValidOut);
endinterface

// File: rtl/pixel_streamer_frame_store.sv
// Simple dual-port frame RAM: one write port, one registered read port, no reset on contents.
module pixel_streamer_frame_store #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Write port and synchronous read port; read data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/pixel_streamer.sv
// Raster-order frame source: loads a frame through a write port, then streams it
// one pixel per cycle with pause and optional inter-row gap insertion.
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int FIXED_POINT_SIZE          = 16,
  parameter int FIXED_POINT_FRACTION_SIZE = 8,
  parameter int IMAGE_WIDTH               = 32,
  parameter int IMAGE_HEIGHT              = 32,
  parameter int ROW_GAP                   = 0
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic                                           wrEn,
  input  logic [count2width(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] wrAddr,
  input  logic [FIXED_POINT_SIZE-1:0]                    wrData,
  input  logic                                           start,
  input  logic                                           pause,
  output logic                                           busy,
  output logic                                           frameDone,
  pixel_streamer_if.master                               px
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW = count2width(IMAGE_SIZE);
  localparam int CW = count2width(IMAGE_WIDTH) + 1;
  localparam int RW = count2width(IMAGE_HEIGHT) + 1;
  localparam int GW = count2width(ROW_GAP) + 1;

  // The fraction width only travels with the pixel format; reject nonsense values.
  if (FIXED_POINT_FRACTION_SIZE < 0 || FIXED_POINT_FRACTION_SIZE > FIXED_POINT_SIZE) begin : g_bad_frac
    $error("FIXED_POINT_FRACTION_SIZE out of range");
  end

  logic [1:0]                  r_sync;
  logic                        w_rst_n;
  state_t                      r_state, w_state_nxt;
  logic                        r_start_q;
  logic [CW-1:0]               r_col;
  logic [RW-1:0]               r_row;
  logic [AW-1:0]               r_idx;
  logic [GW-1:0]               r_gap;
  logic                        r_valid, r_done;
  logic                        w_rd_en, w_wr_en, w_addr_ok, w_busy;
  logic                        w_col_last, w_row_last, w_gap_last;
  logic [FIXED_POINT_SIZE-1:0] w_rd_data;

  // Reset asserts immediately; release is delayed two clocks to avoid metastable exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  end
  assign w_rst_n = resetn & r_sync[1];

  assign w_col_last = (r_col == CW'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMAGE_HEIGHT - 1));
  assign w_gap_last = (r_gap == GW'(ROW_GAP - 1));

  // Busy covers the whole frame plus the cycle carrying the last pixel.
  assign w_busy = (r_state != ST_IDLE) | r_done;

  // A power-of-two frame fills the address space, so every address is in range.
  if (IMAGE_SIZE == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = ({1'b0, wrAddr} < (AW+1)'(IMAGE_SIZE));
  end

  assign w_wr_en = wrEn & ~w_busy & w_addr_ok;

  // Start is registered once in IDLE; the extra stage sets the start-to-busy latency.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_start_q <= 1'b0;
    else          r_start_q <= start & (r_state == ST_IDLE) & ~r_start_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_start_q) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (!pause) begin
          w_rd_en = 1'b1;
          if (w_col_last) begin
            if (w_row_last)       w_state_nxt = ST_IDLE;
            else if (ROW_GAP > 0) w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (w_gap_last) w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters: cleared in IDLE, advanced per issued read, held on pause and in GAP.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_idx <= '0;
      r_gap <= '0;
    end else begin
      if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
      else                   r_gap <= '0;
      if (r_state == ST_IDLE) begin
        r_col <= '0;
        r_row <= '0;
        r_idx <= '0;
      end else if (w_rd_en) begin
        r_idx <= r_idx + 1'b1;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Output flags aligned with the RAM read data.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      r_done  <= w_rd_en & w_col_last & w_row_last;
    end
  end

  pixel_streamer_frame_store #(
    .DW    (FIXED_POINT_SIZE),
    .DEPTH (IMAGE_SIZE),
    .AW    (AW)
  ) u_frame_store (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wrAddr),
    .i_wr_data (wrData),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  assign px.dataOut      = r_valid ? w_rd_data : '0;
  assign px.dataValidOut = r_valid;
  assign busy            = w_busy;
  assign frameDone       = r_done;

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: a no-gap and a gap-3 instance run side by side on a 4x4 frame.
module tb_pixel_streamer;
  localparam int W = 4, H = 4, NP = W * H, SZ = 8192;
  typedef struct { int t; logic [15:0] d; } samp_t;

  logic        clk = 1'b0, resetn = 1'b0, wrEn = 1'b0, pause = 1'b0;
  logic [1:0]  start_v = 2'b00;
  logic [3:0]  wrAddr = '0;
  logic [15:0] wrData = '0;
  logic [1:0]  busy_v, done_v;

  int    cyc = 0, total = 0, bad = 0, zero_bad = 0;
  bit    pause_at [SZ];
  bit    busy_at [2][SZ];
  samp_t cap [2][$];
  int    done_q [2][$];
  logic [15:0] img [NP];

  pixel_streamer_if #(.FIXED_POINT_SIZE(16)) if0 ();
  pixel_streamer_if #(.FIXED_POINT_SIZE(16)) if3 ();

  pixel_streamer #(.FIXED_POINT_SIZE(16), .FIXED_POINT_FRACTION_SIZE(8), .IMAGE_WIDTH(W),
                   .IMAGE_HEIGHT(H), .ROW_GAP(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .start(start_v[0]), .pause(pause), .busy(busy_v[0]), .frameDone(done_v[0]), .px(if0));

  pixel_streamer #(.FIXED_POINT_SIZE(16), .FIXED_POINT_FRACTION_SIZE(8), .IMAGE_WIDTH(W),
                   .IMAGE_HEIGHT(H), .ROW_GAP(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .start(start_v[1]), .pause(pause), .busy(busy_v[1]), .frameDone(done_v[1]), .px(if3));

  always #5 clk = ~clk;

  // Edge counter; pause_at[e] holds the pause level seen by edge e.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pause_at[(cyc + 1) % SZ] <= pause;
  end

  // Capture outputs of both instances between edges.
  always @(negedge clk) begin
    busy_at[0][cyc % SZ] = busy_v[0];
    busy_at[1][cyc % SZ] = busy_v[1];
    if (if0.dataValidOut === 1'b1) cap[0].push_back('{t: cyc, d: if0.dataOut});
    else if (if0.dataOut !== 16'h0) zero_bad++;
    if (if3.dataValidOut === 1'b1) cap[1].push_back('{t: cyc, d: if3.dataOut});
    else if (if3.dataOut !== 16'h0) zero_bad++;
    if (done_v[0] === 1'b1) done_q[0].push_back(cyc);
    if (done_v[1] === 1'b1) done_q[1].push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gapof(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Reference timing: pixel p of a frame whose start was sampled at edge n.
  // One pixel per edge from n+2, each pixel waits out paused edges, and every
  // row except the last is followed by g edges that pause cannot extend.
  function automatic int exp_time(input int n, input int g, input int p);
    int t = n + 2;
    for (int q = 0; q < p; q++) begin
      while (pause_at[t % SZ]) t++;
      t++;
      if (q % W == W - 1) t += g;
    end
    while (pause_at[t % SZ]) t++;
    return t;
  endfunction

  task automatic clear_caps();
    for (int k = 0; k < 2; k++) begin
      cap[k].delete();
      done_q[k].delete();
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      wrEn = 1'b1; wrAddr = 4'(i); wrData = 16'($urandom); img[i] = wrData;
    end
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic launch(output int n);
    @(negedge clk);
    start_v = 2'b11; n = cyc + 1;
    @(negedge clk);
    start_v = 2'b00;
  endtask

  task automatic launch_wr(input logic [15:0] v, output int n);
    @(negedge clk);
    start_v = 2'b11; wrEn = 1'b1; wrAddr = 4'd0; wrData = v; img[0] = v; n = cyc + 1;
    @(negedge clk);
    start_v = 2'b00; wrEn = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    repeat (2) @(negedge clk);
    while (busy_v !== 2'b00 && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (busy_v !== 2'b00) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b required 00", nm, busy_v);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({if0.dataValidOut, if0.dataOut, if3.dataValidOut, if3.dataOut, busy_v, done_v} !== '0) begin
      bad++;
      $display("FAIL reset_held: v0=%b d0=%h v3=%b d3=%h busy=%b done=%b required all 0",
               if0.dataValidOut, if0.dataOut, if3.dataValidOut, if3.dataOut, busy_v, done_v);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({if0.dataValidOut, if0.dataOut, if3.dataValidOut, if3.dataOut, busy_v, done_v} !== '0) begin
      bad++;
      $display("FAIL reset_release: v0=%b v3=%b busy=%b done=%b required all 0",
               if0.dataValidOut, if3.dataValidOut, busy_v, done_v);
    end
  endtask

  // Random frames, no pause: exact timing, data, frameDone, busy edges, frame length.
  task automatic test_stream();
    int n, g, lst;
    for (int f = 0; f < 2; f++) begin
      load_img();
      clear_caps();
      launch(n);
      wait_idle("stream");
      for (int k = 0; k < 2; k++) begin
        g = gapof(k);
        lst = exp_time(n, g, NP - 1);
        total++;
        if (cap[k].size() != NP) begin
          bad++; $display("FAIL stream_count dut%0d: got %0d required %0d", k, cap[k].size(), NP);
        end
        for (int p = 0; p < NP && p < cap[k].size(); p++) begin
          total++;
          if (cap[k][p].t != exp_time(n, g, p) || cap[k][p].d !== img[p]) begin
            bad++;
            $display("FAIL stream_pix dut%0d p%0d: t=%0d d=%h required t=%0d d=%h",
                     k, p, cap[k][p].t, cap[k][p].d, exp_time(n, g, p), img[p]);
          end
        end
        total++;
        if (done_q[k].size() != 1 || (done_q[k].size() == 1 && done_q[k][0] != lst)) begin
          bad++; $display("FAIL stream_done dut%0d: count=%0d required one pulse at %0d", k, done_q[k].size(), lst);
        end
        total++;
        if ({busy_at[k][n % SZ], busy_at[k][(n + 1) % SZ], busy_at[k][lst % SZ], busy_at[k][(lst + 1) % SZ]} !== 4'b0110) begin
          bad++;
          $display("FAIL stream_busy dut%0d: %b%b%b%b required 0110", k, busy_at[k][n % SZ],
                   busy_at[k][(n + 1) % SZ], busy_at[k][lst % SZ], busy_at[k][(lst + 1) % SZ]);
        end
        if (cap[k].size() == NP) begin
          total++;
          if (cap[k][NP-1].t - cap[k][0].t + 1 != NP + (H - 1) * g) begin
            bad++;
            $display("FAIL stream_len dut%0d: got %0d required %0d", k,
                     cap[k][NP-1].t - cap[k][0].t + 1, NP + (H - 1) * g);
          end
        end
      end
    end
  endtask

  // Pause for 5 edges just as pixel 6 of the no-gap instance is due.
  task automatic test_pause();
    int n, g;
    load_img();
    clear_caps();
    launch(n);
    repeat (7) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    pause = 1'b0;
    wait_idle("pause");
    for (int k = 0; k < 2; k++) begin
      g = gapof(k);
      total++;
      if (cap[k].size() != NP) begin
        bad++; $display("FAIL pause_count dut%0d: got %0d required %0d", k, cap[k].size(), NP);
      end
      for (int p = 0; p < NP && p < cap[k].size(); p++) begin
        total++;
        if (cap[k][p].t != exp_time(n, g, p) || cap[k][p].d !== img[p]) begin
          bad++;
          $display("FAIL pause_pix dut%0d p%0d: t=%0d d=%h required t=%0d d=%h",
                   k, p, cap[k][p].t, cap[k][p].d, exp_time(n, g, p), img[p]);
        end
      end
    end
    if (cap[0].size() > 6) begin
      total++;
      if (cap[0][6].t - cap[0][5].t != 6) begin
        bad++; $display("FAIL pause_hole: spacing %0d required 6", cap[0][6].t - cap[0][5].t);
      end
    end
  endtask

  // Write and start while busy are dropped; then a start with a same-cycle write to address 0.
  task automatic test_busy_ignore();
    int n;
    logic [15:0] v;
    load_img();
    clear_caps();
    launch(n);
    repeat (4) @(negedge clk);
    wrEn = 1'b1; wrAddr = 4'd5; wrData = 16'hFFFF; start_v = 2'b11;
    @(negedge clk);
    wrEn = 1'b0; start_v = 2'b00;
    wait_idle("busy1");
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cap[k].size() != NP || done_q[k].size() != 1) begin
        bad++; $display("FAIL busy_once dut%0d: pixels=%0d dones=%0d required %0d and 1", k, cap[k].size(), done_q[k].size(), NP);
      end
    end
    clear_caps();
    v = 16'($urandom);
    launch_wr(v, n);
    wait_idle("busy2");
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cap[k].size() != NP) begin
        bad++; $display("FAIL busy_count dut%0d: got %0d required %0d", k, cap[k].size(), NP);
      end
      for (int p = 0; p < NP && p < cap[k].size(); p++) begin
        total++;
        if (cap[k][p].t != exp_time(n, gapof(k), p) || cap[k][p].d !== img[p]) begin
          bad++;
          $display("FAIL busy_pix dut%0d p%0d: t=%0d d=%h required t=%0d d=%h",
                   k, p, cap[k][p].t, cap[k][p].d, exp_time(n, gapof(k), p), img[p]);
        end
      end
    end
  endtask

  // Reset mid row 2: outputs drop immediately, no resume, memory survives.
  task automatic test_reset_mid();
    int n;
    clear_caps();
    launch(n);
    repeat (11) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({if0.dataValidOut, if0.dataOut, if3.dataValidOut, if3.dataOut, busy_v, done_v} !== '0) begin
      bad++;
      $display("FAIL rstmid_async: v0=%b d0=%h v3=%b d3=%h busy=%b done=%b required all 0",
               if0.dataValidOut, if0.dataOut, if3.dataValidOut, if3.dataOut, busy_v, done_v);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_caps();
    repeat (6) @(negedge clk);
    total++;
    if (busy_v !== 2'b00 || cap[0].size() != 0 || cap[1].size() != 0) begin
      bad++; $display("FAIL rstmid_noresume: busy=%b pix=%0d/%0d required 00 and 0/0", busy_v, cap[0].size(), cap[1].size());
    end
    clear_caps();
    launch(n);
    wait_idle("rstmid");
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cap[k].size() != NP) begin
        bad++; $display("FAIL rstmid_count dut%0d: got %0d required %0d", k, cap[k].size(), NP);
      end
      for (int p = 0; p < NP && p < cap[k].size(); p++) begin
        total++;
        if (cap[k][p].t != exp_time(n, gapof(k), p) || cap[k][p].d !== img[p]) begin
          bad++;
          $display("FAIL rstmid_pix dut%0d p%0d: t=%0d d=%h required t=%0d d=%h",
                   k, p, cap[k][p].t, cap[k][p].d, exp_time(n, gapof(k), p), img[p]);
        end
      end
    end
  endtask

  // Second start sampled on the edge busy falls; second frame fed through a 3x3 window model.
  task automatic test_back_to_back();
    int n, l0, l1, lk, fc;
    logic [15:0] sr [2*W+3];
    load_img();
    clear_caps();
    launch(n);
    l0 = exp_time(n, 0, NP - 1);
    l1 = exp_time(n, 3, NP - 1);
    forever begin
      @(negedge clk);
      start_v = {cyc == l1, cyc == l0};
      if (cyc > l1) break;
    end
    start_v = 2'b00;
    wait_idle("b2b");
    for (int k = 0; k < 2; k++) begin
      lk = (k == 0) ? l0 : l1;
      total++;
      if (cap[k].size() != 2 * NP || done_q[k].size() != 2) begin
        bad++; $display("FAIL b2b_count dut%0d: pixels=%0d dones=%0d required %0d and 2", k, cap[k].size(), done_q[k].size(), 2 * NP);
      end
      if (cap[k].size() > NP) begin
        total++;
        if (cap[k][NP].t != lk + 3) begin
          bad++; $display("FAIL b2b_first dut%0d: t=%0d required %0d", k, cap[k][NP].t, lk + 3);
        end
      end
      for (int p = 0; p < 2 * NP && p < cap[k].size(); p++) begin
        total++;
        if (cap[k][p].t != ((p < NP) ? exp_time(n, gapof(k), p) : exp_time(lk + 1, gapof(k), p - NP)) ||
            cap[k][p].d !== img[p % NP]) begin
          bad++;
          $display("FAIL b2b_pix dut%0d p%0d: t=%0d d=%h required d=%h", k, p, cap[k][p].t, cap[k][p].d, img[p % NP]);
        end
      end
    end
    // Line-buffer model: shift register of two rows plus three taps.
    fc = 0;
    for (int i = 0; i < 2 * W + 3; i++) sr[i] = '0;
    for (int p = NP; p < cap[0].size() && p < 2 * NP; p++) begin
      for (int i = 2 * W + 2; i > 0; i--) sr[i] = sr[i-1];
      sr[0] = cap[0][p].d;
      if (fc / W >= 2 && fc % W >= 2) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            total++;
            if (sr[(2 - i) * W + (2 - j)] !== img[(fc / W - 2 + i) * W + (fc % W - 2 + j)]) begin
              bad++;
              $display("FAIL window r%0d c%0d [%0d][%0d]: got %h required %h", fc / W, fc % W, i, j,
                       sr[(2 - i) * W + (2 - j)], img[(fc / W - 2 + i) * W + (fc % W - 2 + j)]);
            end
          end
        end
      end
      fc++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pause();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (zero_bad != 0) begin
      bad++; $display("FAIL idle_zero: %0d non-zero dataOut samples while invalid, required 0", zero_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
# pixel_streamer

Raster-order pixel source for the convolution datapath. It holds one IMAGE_WIDTH x IMAGE_HEIGHT frame of fixed-point pixels in an internal frame store, loaded through a simple write port. On a start request it streams the frame out, one pixel per cycle, on a dataOut/dataValidOut interface that connects directly to the window line buffer's dataIn/dataValidIn. It is the transmitting end of the pixel-stream interface, with pause (stall) and optional inter-row gap insertion.

## Interface
- FIXED_POINT_SIZE, 16, pixel word width
- FIXED_POINT_FRACTION_SIZE, 8, fraction bits; carried for uniform instantiation, no arithmetic uses it
- IMAGE_WIDTH, 32, pixels per row
- IMAGE_HEIGHT, 32, rows per frame
- ROW_GAP, 0, idle cycles inserted after every row except the last
- Reset: one clock; reset is asynchronous and active-low
- clk  in  1  single clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset; assertion is immediate, deassertion goes through a 2-flop synchronizer (internal reset = resetn AND synchronized copy)
- wrEn  in  1  frame-store write strobe
- wrAddr  in  count2width(IMAGE_WIDTH*IMAGE_HEIGHT)  raster pixel index (row*IMAGE_WIDTH+col)
- wrData  in  FIXED_POINT_SIZE  pixel to store
- start  in  1  frame start request, level-sampled
- pause  in  1  stall request; no new pixel is issued while it is high
- dataOut  out  FIXED_POINT_SIZE  streamed pixel; 0 when not valid
- dataValidOut  out  1  dataOut is a valid pixel
- busy  out  1  a frame is in flight
- frameDone  out  1  single-cycle pulse on the last pixel of the frame

## Operation
- States: IDLE, STREAM, GAP.
- IDLE:
  - wrEn with wrAddr < IMAGE_WIDTH*IMAGE_HEIGHT writes wrData. Writes with an out-of-range address are dropped.
  - start=1 goes to STREAM with the read index and column/row counters at 0.
- STREAM, each cycle with pause=0:
  - Issue a read of the current index.
  - Advance the column counter. At column IMAGE_WIDTH-1 the column wraps to 0 and the row advances.
  - Last pixel of a non-final row: go to GAP if ROW_GAP>0, else stay in STREAM.
  - Last pixel of the frame: go to IDLE.
- STREAM with pause=1: counters are held and no read is issued.
- GAP: count ROW_GAP cycles, then return to STREAM. pause is ignored in GAP (the gap is not extended).
- Frame store read is synchronous. A read issued in cycle t produces dataOut/dataValidOut registered at edge t+1.
- All writes (wrEn) are ignored while busy=1.
- start is ignored while busy=1.
- wrEn and start in the same IDLE cycle: the write commits and start is accepted. The written value is visible to the frame, including address 0.
- Frame store contents are not cleared by reset.

## Timing
- Reset values: dataOut=0, dataValidOut=0, busy=0, frameDone=0, state IDLE, all counters 0.
- Reset asserted mid-frame: outputs go to reset values immediately and the frame is abandoned. No resume; the next frame needs a fresh start.
- Latency: start sampled high at edge N gives the first dataValidOut at edge N+2 (pixel 0).
- busy rises at edge N+1. It stays high through the cycle carrying the last pixel and falls on the following edge.
- frameDone is high in the same cycle as the last pixel's dataValidOut.
- Back-to-back frames: start may be accepted on the edge at which busy falls.
- Unpaused frame length, first valid to last valid inclusive: IMAGE_WIDTH*IMAGE_HEIGHT + (IMAGE_HEIGHT-1)*ROW_GAP cycles.
- pause high in cycle t suppresses dataValidOut at t+1 only (one-cycle response). Pixel order is preserved, with no skipped and no duplicated pixels.
- Counter widths: count2width(n)+1, consistent with the line buffer, so compares against IMAGE_WIDTH-1 and IMAGE_HEIGHT-1 never overflow.

## Structure
- Shared params.vh: count2width function, frame-size localparams (IMAGE_SIZE, address width), state encodings.
- One sub-module: frame_store. It is a single-clock simple dual-port RAM (1 write port, 1 synchronous read port), IMAGE_WIDTH*IMAGE_HEIGHT deep x FIXED_POINT_SIZE wide, with no reset on contents.
- Top level: FSM, counters, output register.

## Test plan
- W=H=4, ROW_GAP=0, load pixel i=i, start with no pause -> 16 consecutive valids 0x0000..0x000F. First valid 2 cycles after start; frameDone with 0x000F; busy falls on the next edge.
- W=H=4, ROW_GAP=3 -> valid low for exactly 3 cycles after pixels 3, 7 and 11. 25 cycles from first to last valid.
- pause high for 5 cycles while pixel 6 is next -> 5 invalid cycles, then the stream resumes at 6, 7, ... with no loss or duplicate.
- During busy: wrEn to addr 5 with 0xFFFF, plus a second start pulse -> both ignored. A following frame still outputs 5 at index 5, and the current frame completes once.
- resetn low mid-row 2 -> all outputs 0 asynchronously. After release plus synchronizer and start: the full frame from pixel 0, with memory contents intact.
- start on the edge busy falls -> second frame accepted, its pixel 0 arrives 2 cycles later. Drive it into the line buffer (K=3) and check window pixel values.
